// File: rtl/lfsr_ctrl_if.sv
// Handshake bundle for lfsr_ctrl: seed load, generate request, and output word stream.
interface lfsr_ctrl_if #(
  parameter int NBITS = 8,
  parameter int CNTW  = 8
);
  logic             seed_val;
  logic             seed_rdy;
  logic [NBITS-1:0] seed;
  logic             req_val;
  logic             req_rdy;
  logic [CNTW-1:0]  req_cnt;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_data;
  logic             busy;

  modport slave (
    input  seed_val, seed, req_val, req_cnt, out_rdy,
    output seed_rdy, req_rdy, out_val, out_data, busy
  );

  modport master (
    output seed_val, seed, req_val, req_cnt, out_rdy,
    input  seed_rdy, req_rdy, out_val, out_data, busy
  );
endinterface

// File: rtl/lfsr_ctrl.sv
// Fibonacci LFSR sequencer: seeds the state register, advances it STEPS shifts per
// word and streams req_cnt words per request over a valid/ready output.
module lfsr_ctrl #(
  parameter int               NBITS     = 8,
  parameter logic [NBITS-1:0] TAPS      = 8'hB8,
  parameter int               STEPS     = 1,
  parameter int               CNTW      = 8,
  parameter logic [NBITS-1:0] SEED_INIT = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  lfsr_ctrl_if.slave  bus
);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_SHIFT,
    S_EMIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_q;
  logic [NBITS-1:0] w_q_d;
  logic             w_q_en;
  logic [NBITS-1:0] w_nxt;
  logic             w_fb;
  logic [SW-1:0]    r_step;
  logic [SW-1:0]    w_step_nxt;
  logic [CNTW-1:0]  r_words;
  logic [CNTW-1:0]  w_words_nxt;

  assign w_fb  = ^(r_q & TAPS);
  assign w_nxt = {r_q[NBITS-2:0], w_fb};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_q     <= '0;
      r_step  <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_words <= w_words_nxt;
      if (w_q_en) begin
        r_q <= w_q_d;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_en      = 1'b0;
    w_q_d       = w_nxt;
    w_step_nxt  = r_step;
    w_words_nxt = r_words;
    case (r_state)
      S_INIT: begin
        w_q_en      = 1'b1;
        w_q_d       = SEED_INIT;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // Seed has priority; a simultaneous request sees req_rdy=0 and retries.
        if (bus.seed_val) begin
          w_q_en = 1'b1;
          w_q_d  = (bus.seed == '0) ? SEED_INIT : bus.seed;
        end else if (bus.req_val && (bus.req_cnt != '0)) begin
          w_words_nxt = bus.req_cnt;
          w_step_nxt  = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_q_en = 1'b1;
        if (r_step == SW'(STEPS - 1)) begin
          w_step_nxt  = '0;
          w_state_nxt = S_EMIT;
        end else begin
          w_step_nxt = SW'(r_step + 1'b1);
        end
      end
      S_EMIT: begin
        if (bus.out_rdy) begin
          w_words_nxt = r_words - 1'b1;
          w_step_nxt  = '0;
          w_state_nxt = (r_words == CNTW'(1)) ? S_IDLE : S_SHIFT;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign bus.seed_rdy = (r_state == S_IDLE);
  assign bus.req_rdy  = (r_state == S_IDLE) && !bus.seed_val;
  assign bus.out_val  = (r_state == S_EMIT);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.out_data = r_q;
endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with hand-computed LFSR words (TAPS=B8, STEPS=1).
module tb_lfsr_ctrl;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  lfsr_ctrl_if #(.NBITS(8), .CNTW(8)) bus ();

  lfsr_ctrl #(
    .NBITS(8), .TAPS(8'hB8), .STEPS(1), .CNTW(8), .SEED_INIT(8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_w [4];
  logic       seen [256];
  logic [7:0] last_w;
  int         nwords;
  int         ndup;
  int         nval;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_w[0] = 8'h02; exp_w[1] = 8'h04; exp_w[2] = 8'h08; exp_w[3] = 8'h11;
    rst = 1'b1;
    bus.seed_val = 1'b0; bus.seed = '0;
    bus.req_val  = 1'b0; bus.req_cnt = '0;
    bus.out_rdy  = 1'b0;
    repeat (3) step();
    chk("rst_busy",     32'(bus.busy),     32'd1);
    chk("rst_seed_rdy", 32'(bus.seed_rdy), 32'd0);
    chk("rst_req_rdy",  32'(bus.req_rdy),  32'd0);
    chk("rst_out_val",  32'(bus.out_val),  32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);

    rst = 1'b0;
    #1;
    chk("init_busy", 32'(bus.busy), 32'd1);
    step();
    chk("idle_q",        32'(bus.out_data), 32'h01);
    chk("idle_seed_rdy", 32'(bus.seed_rdy), 32'd1);
    chk("idle_req_rdy",  32'(bus.req_rdy),  32'd1);
    chk("idle_out_val",  32'(bus.out_val),  32'd0);
    chk("idle_busy",     32'(bus.busy),     32'd0);

    // Seed 0x01 then request 4 words with out_rdy held high
    bus.seed_val = 1'b1; bus.seed = 8'h01;
    step();
    bus.seed_val = 1'b0;
    bus.req_val = 1'b1; bus.req_cnt = 8'd4; bus.out_rdy = 1'b1;
    #1;
    chk("req4_rdy", 32'(bus.req_rdy), 32'd1);
    step();
    bus.req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("req4_shift_val%0d", i), 32'(bus.out_val), 32'd0);
      step();
      chk($sformatf("req4_val%0d", i),  32'(bus.out_val),  32'd1);
      chk($sformatf("req4_data%0d", i), 32'(bus.out_data), 32'(exp_w[i]));
      step();
    end
    chk("req4_done_busy", 32'(bus.busy),     32'd0);
    chk("req4_done_val",  32'(bus.out_val),  32'd0);
    chk("req4_done_q",    32'(bus.out_data), 32'h11);

    // Zero seed with a simultaneous request: seed wins, request retried
    bus.seed_val = 1'b1; bus.seed = 8'h00;
    bus.req_val = 1'b1; bus.req_cnt = 8'd2;
    #1;
    chk("both_req_rdy",  32'(bus.req_rdy),  32'd0);
    chk("both_seed_rdy", 32'(bus.seed_rdy), 32'd1);
    step();
    bus.seed_val = 1'b0;
    #1;
    chk("seed0_q",       32'(bus.out_data), 32'h01);
    chk("retry_req_rdy", 32'(bus.req_rdy),  32'd1);
    step();
    bus.req_val = 1'b0; bus.out_rdy = 1'b0;
    chk("retry_busy", 32'(bus.busy), 32'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_val%0d", i),  32'(bus.out_val),  32'd1);
      chk($sformatf("stall_data%0d", i), 32'(bus.out_data), 32'h02);
      step();
    end
    bus.out_rdy = 1'b1;
    chk("stall_end_data", 32'(bus.out_data), 32'h02);
    step();
    chk("resume_shift_val", 32'(bus.out_val), 32'd0);
    step();
    chk("resume_val",  32'(bus.out_val),  32'd1);
    chk("resume_data", 32'(bus.out_data), 32'h04);
    step();
    chk("resume_done_busy", 32'(bus.busy), 32'd0);

    // Full period from seed 0x01
    bus.seed_val = 1'b1; bus.seed = 8'h01;
    step();
    bus.seed_val = 1'b0;
    bus.req_val = 1'b1; bus.req_cnt = 8'd255;
    step();
    bus.req_val = 1'b0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    nwords = 0; ndup = 0; last_w = '0;
    for (int c = 0; c < 600 && bus.busy; c++) begin
      if (bus.out_val) begin
        if (seen[bus.out_data] || bus.out_data == 8'h00) ndup++;
        seen[bus.out_data] = 1'b1;
        last_w = bus.out_data;
        nwords++;
      end
      step();
    end
    chk("period_busy_done", 32'(bus.busy), 32'd0);
    chk("period_count",     32'(nwords),   32'd255);
    chk("period_dups",      32'(ndup),     32'd0);
    chk("period_last",      32'(last_w),   32'h01);

    // req_cnt == 0: accepted, nothing emitted
    bus.req_val = 1'b1; bus.req_cnt = 8'd0;
    #1;
    chk("zero_req_rdy", 32'(bus.req_rdy), 32'd1);
    step();
    bus.req_val = 1'b0;
    nval = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_val || bus.busy) nval++;
      step();
    end
    chk("zero_no_words", 32'(nval),          32'd0);
    chk("zero_q_kept",   32'(bus.out_data),  32'h01);

    // Reset while emitting the third of five words (3 left)
    bus.req_val = 1'b1; bus.req_cnt = 8'd5;
    step();
    bus.req_val = 1'b0;
    repeat (5) step();
    chk("mid_val",  32'(bus.out_val),  32'd1);
    chk("mid_data", 32'(bus.out_data), 32'h08);
    rst = 1'b1;
    step();
    chk("mid_rst_val",  32'(bus.out_val),  32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'h00);
    chk("mid_rst_busy", 32'(bus.busy),     32'd1);
    rst = 1'b0;
    step();
    chk("mid_idle_q",    32'(bus.out_data), 32'h01);
    chk("mid_idle_busy", 32'(bus.busy),     32'd0);
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_val) nval++;
      step();
    end
    chk("mid_no_words", 32'(nval), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
